// File: rtl/cv32e40p_x_resp_stub.sv
// Coprocessor-side X-interface responder stub: accepts custom-0 offloads,
// executes ADD/SUB/XOR in one cycle and MUL/MAC over MUL_LATENCY cycles,
// and returns results in acceptance order through a small result FIFO.
// Optional feature macro: CV32E40P_X_RESP_STUB_ERR_EN (f3=7 returns an error result).
module cv32e40p_x_resp_stub #(
  parameter logic [6:0] OPCODE      = 7'h0B,
  parameter int         FIFO_DEPTH  = 2,
  parameter int         MUL_LATENCY = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             x_valid_i,
  output logic             x_ready_o,
  input  logic [31:0]      x_instr_data_i,
  input  logic [2:0][31:0] x_rs_i,
  input  logic [2:0]       x_rs_valid_i,
  input  logic             x_rd_clean_i,
  output logic             x_accept_o,
  output logic             x_is_mem_op_o,
  output logic             x_writeback_o,
  output logic             x_rvalid_o,
  input  logic             x_rready_i,
  output logic [4:0]       x_rd_o,
  output logic [31:0]      x_data_o,
  output logic             x_dualwb_o,
  output logic             x_type_o,
  output logic             x_error_o
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int LAT_W = $clog2(MUL_LATENCY);
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(FIFO_DEPTH);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e           state;
  logic [LAT_W-1:0] cnt;
  logic [31:0]      op_a, op_b, op_c;
  logic [4:0]       mul_rd;
  logic [31:0]      mul_res;

  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [4:0]  rd;
  logic        op_supported, is_mul, is_mac;
  logic [2:0]  need_rs;
  logic        operands_ok, inflight, handshake, accept_hs;
  logic [31:0] alu_res;
  logic        unused_bits;

  logic [31:0]      fifo_data [FIFO_DEPTH];
  logic [4:0]       fifo_rd   [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] fifo_count;
  logic [CNT_W:0]   occupancy;
  logic             push, pop;
  logic [31:0]      push_data;
  logic [4:0]       push_rd;

  assign opc         = x_instr_data_i[6:0];
  assign f3          = x_instr_data_i[14:12];
  assign rd          = x_instr_data_i[11:7];
  assign unused_bits = ^x_instr_data_i[31:15];

`ifdef CV32E40P_X_RESP_STUB_ERR_EN
  logic is_err;
  logic fifo_err [FIFO_DEPTH];
`endif

  // Decode the offloaded instruction into op class and support flags.
  always_comb begin
    op_supported = 1'b0;
    is_mul       = 1'b0;
    is_mac       = 1'b0;
`ifdef CV32E40P_X_RESP_STUB_ERR_EN
    is_err       = 1'b0;
`endif
    if (opc == OPCODE) begin
      case (f3)
        3'd0, 3'd1, 3'd2: op_supported = 1'b1;
        3'd3: begin op_supported = 1'b1; is_mul = 1'b1; end
        3'd4: begin op_supported = 1'b1; is_mul = 1'b1; is_mac = 1'b1; end
`ifdef CV32E40P_X_RESP_STUB_ERR_EN
        3'd7: begin op_supported = 1'b1; is_err = 1'b1; end
`endif
        default: op_supported = 1'b0;
      endcase
    end
  end

  // Single-cycle ALU result; the error op falls into the default and returns 0.
  always_comb begin
    case (f3)
      3'd0:    alu_res = x_rs_i[0] + x_rs_i[1];
      3'd1:    alu_res = x_rs_i[0] - x_rs_i[1];
      3'd2:    alu_res = x_rs_i[0] ^ x_rs_i[1];
      default: alu_res = '0;
    endcase
  end

  // Rejected offloads never stall; accepted ones wait for operands and a clean rd.
  assign need_rs     = is_mac ? 3'b111 : 3'b011;
  assign operands_ok = !op_supported ||
                       (((x_rs_valid_i & need_rs) == need_rs) && x_rd_clean_i);
  // A multicycle op in flight holds one FIFO slot in reserve.
  assign inflight    = (state == BUSY);
  assign occupancy   = (CNT_W + 1)'(fifo_count) + (CNT_W + 1)'(inflight);

  assign x_ready_o     = !rst_i && (state == IDLE) && (occupancy < DEPTH_C) && operands_ok;
  assign x_accept_o    = op_supported;
  assign x_writeback_o = op_supported;
  assign x_is_mem_op_o = 1'b0;
  assign x_dualwb_o    = 1'b0;
  assign x_type_o      = 1'b0;

  assign handshake = x_valid_i && x_ready_o;
  assign accept_hs = handshake && op_supported;

  assign mul_res = op_a * op_b + op_c;

  // Sequencer: ALU ops complete in IDLE, MUL/MAC count down in BUSY.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: if (accept_hs && is_mul) begin
          state <= BUSY;
          cnt   <= LAT_W'(MUL_LATENCY - 1);
        end
        BUSY: begin
          cnt <= cnt - LAT_W'(1);
          if (cnt == LAT_W'(1)) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Multiplier operand capture; only meaningful while BUSY, so no reset needed.
  always_ff @(posedge clk_i) begin
    if (accept_hs && is_mul && (state == IDLE)) begin
      op_a   <= x_rs_i[0];
      op_b   <= x_rs_i[1];
      op_c   <= is_mac ? x_rs_i[2] : '0;
      mul_rd <= rd;
    end
  end

  // BUSY never overlaps a handshake, so the two push sources are exclusive.
  assign push      = (accept_hs && !is_mul) || ((state == BUSY) && (cnt == LAT_W'(1)));
  assign push_data = (state == BUSY) ? mul_res : alu_res;
  assign push_rd   = (state == BUSY) ? mul_rd : rd;
  assign pop       = x_rvalid_o && x_rready_i;

  // FIFO bookkeeping: pointers wrap at FIFO_DEPTH, simultaneous push/pop keeps count.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= (rd_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // FIFO storage write.
  // NOTE: storage is not reset; fifo_count gates every read, and outputs are masked to 0 when empty.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_data[wr_ptr] <= push_data;
      fifo_rd[wr_ptr]   <= push_rd;
`ifdef CV32E40P_X_RESP_STUB_ERR_EN
      fifo_err[wr_ptr]  <= (state == IDLE) && is_err;
`endif
    end
  end

  assign x_rvalid_o = (fifo_count != '0);
  assign x_data_o   = x_rvalid_o ? fifo_data[rd_ptr] : '0;
  assign x_rd_o     = x_rvalid_o ? fifo_rd[rd_ptr] : '0;
`ifdef CV32E40P_X_RESP_STUB_ERR_EN
  assign x_error_o  = x_rvalid_o && fifo_err[rd_ptr];
`else
  assign x_error_o  = 1'b0;
`endif

endmodule

// File: tb/tb_cv32e40p_x_resp_stub.sv
// Directed self-checking bench for cv32e40p_x_resp_stub (default parameters).
module tb_cv32e40p_x_resp_stub;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             x_valid_i;
  logic             x_ready_o;
  logic [31:0]      x_instr_data_i;
  logic [2:0][31:0] x_rs_i;
  logic [2:0]       x_rs_valid_i;
  logic             x_rd_clean_i;
  logic             x_accept_o;
  logic             x_is_mem_op_o;
  logic             x_writeback_o;
  logic             x_rvalid_o;
  logic             x_rready_i;
  logic [4:0]       x_rd_o;
  logic [31:0]      x_data_o;
  logic             x_dualwb_o;
  logic             x_type_o;
  logic             x_error_o;

  int n_checks = 0;
  int n_errors = 0;

  cv32e40p_x_resp_stub dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .x_valid_i      (x_valid_i),
    .x_ready_o      (x_ready_o),
    .x_instr_data_i (x_instr_data_i),
    .x_rs_i         (x_rs_i),
    .x_rs_valid_i   (x_rs_valid_i),
    .x_rd_clean_i   (x_rd_clean_i),
    .x_accept_o     (x_accept_o),
    .x_is_mem_op_o  (x_is_mem_op_o),
    .x_writeback_o  (x_writeback_o),
    .x_rvalid_o     (x_rvalid_o),
    .x_rready_i     (x_rready_i),
    .x_rd_o         (x_rd_o),
    .x_data_o       (x_data_o),
    .x_dualwb_o     (x_dualwb_o),
    .x_type_o       (x_type_o),
    .x_error_o      (x_error_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle 1 ns past the edge.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [31:0] enc(input logic [2:0] f3, input logic [4:0] rd,
                                      input logic [6:0] opc);
    return {17'b0, f3, rd, opc};
  endfunction

  task automatic offer(input logic [31:0] instr, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] c);
    x_valid_i      = 1'b1;
    x_instr_data_i = instr;
    x_rs_i[0]      = a;
    x_rs_i[1]      = b;
    x_rs_i[2]      = c;
    #1;
  endtask

  task automatic drop();
    x_valid_i = 1'b0;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int seen;
    x_valid_i      = 1'b0;
    x_instr_data_i = '0;
    x_rs_i         = '0;
    x_rs_valid_i   = 3'b111;
    x_rd_clean_i   = 1'b1;
    x_rready_i     = 1'b1;
    rst_i          = 1'b1;
    step();
    step();

    // Reset state
    check("rst_ready",  32'(x_ready_o), 0);
    check("rst_rvalid", 32'(x_rvalid_o), 0);
    check("rst_rd",     32'(x_rd_o), 0);
    check("rst_data",   x_data_o, 0);
    check("rst_error",  32'(x_error_o), 0);
    rst_i = 1'b0;
    step();
    check("idle_ready", 32'(x_ready_o), 1);

    // ADD rd=3: 5+7
    offer(enc(3'd0, 5'd3, 7'h0B), 32'd5, 32'd7, 32'd0);
    check("add_ready",  32'(x_ready_o), 1);
    check("add_accept", 32'(x_accept_o), 1);
    check("add_wb",     32'(x_writeback_o), 1);
    check("const_mem",  32'(x_is_mem_op_o), 0);
    check("const_dual", 32'(x_dualwb_o), 0);
    check("const_type", 32'(x_type_o), 0);
    step();
    drop();
    check("add_rvalid", 32'(x_rvalid_o), 1);
    check("add_rd",     32'(x_rd_o), 3);
    check("add_data",   x_data_o, 32'd12);
    step();
    check("add_popped", 32'(x_rvalid_o), 0);

    // MUL rd=5: FFFFFFFF*2, three-cycle latency
    offer(enc(3'd3, 5'd5, 7'h0B), 32'hFFFF_FFFF, 32'd2, 32'd0);
    check("mul_accept", 32'(x_accept_o), 1);
    check("mul_ready",  32'(x_ready_o), 1);
    step();
    drop();
    check("mul_busy_ready1",  32'(x_ready_o), 0);
    check("mul_busy_rvalid1", 32'(x_rvalid_o), 0);
    step();
    check("mul_busy_ready2",  32'(x_ready_o), 0);
    check("mul_busy_rvalid2", 32'(x_rvalid_o), 0);
    step();
    check("mul_rvalid", 32'(x_rvalid_o), 1);
    check("mul_data",   x_data_o, 32'hFFFF_FFFE);
    check("mul_rd",     32'(x_rd_o), 5);
    check("mul_idle_ready", 32'(x_ready_o), 1);
    step();
    check("mul_popped", 32'(x_rvalid_o), 0);

    // Backpressure: ADD, XOR fill the FIFO, SUB must wait
    x_rready_i = 1'b0;
    offer(enc(3'd0, 5'd1, 7'h0B), 32'd10, 32'd20, 32'd0);
    step();
    offer(enc(3'd2, 5'd2, 7'h0B), 32'h0000_F0F0, 32'h0000_0FF0, 32'd0);
    check("bp_xor_ready", 32'(x_ready_o), 1);
    step();
    offer(enc(3'd1, 5'd4, 7'h0B), 32'd100, 32'd1, 32'd0);
    check("bp_full_ready", 32'(x_ready_o), 0);
    check("bp_head_rd",    32'(x_rd_o), 1);
    check("bp_head_data",  x_data_o, 32'd30);
    step();
    check("bp_hold_ready", 32'(x_ready_o), 0);
    check("bp_hold_data",  x_data_o, 32'd30);
    check("bp_hold_rd",    32'(x_rd_o), 1);
    x_rready_i = 1'b1;
    #1;
    step();
    check("bp_second_rd",   32'(x_rd_o), 2);
    check("bp_second_data", x_data_o, 32'h0000_FF00);
    check("bp_ready_back",  32'(x_ready_o), 1);
    step();
    drop();
    check("bp_third_rvalid", 32'(x_rvalid_o), 1);
    check("bp_third_rd",     32'(x_rd_o), 4);
    check("bp_third_data",   x_data_o, 32'd99);
    step();
    check("bp_drained", 32'(x_rvalid_o), 0);

    // Foreign opcode: handshake completes but is rejected, even with no operands
    x_rs_valid_i = 3'b000;
    offer(enc(3'd0, 5'd6, 7'h33), 32'd1, 32'd1, 32'd0);
    check("rej_ready",  32'(x_ready_o), 1);
    check("rej_accept", 32'(x_accept_o), 0);
    check("rej_wb",     32'(x_writeback_o), 0);
    step();
    drop();
    x_rs_valid_i = 3'b111;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (x_rvalid_o) seen++;
      step();
    end
    check("rej_no_resp", 32'(seen), 0);

    // Unsupported funct3=5 on the right opcode
    offer(enc(3'd5, 5'd6, 7'h0B), 32'd0, 32'd0, 32'd0);
    check("f3_5_accept", 32'(x_accept_o), 0);
    drop();

    // MAC waits for rs2: 3*4+5
    x_rs_valid_i = 3'b011;
    offer(enc(3'd4, 5'd7, 7'h0B), 32'd3, 32'd4, 32'd5);
    check("mac_wait_ready1", 32'(x_ready_o), 0);
    step();
    check("mac_wait_ready2", 32'(x_ready_o), 0);
    x_rs_valid_i = 3'b111;
    #1;
    check("mac_go_ready", 32'(x_ready_o), 1);
    step();
    drop();
    step();
    check("mac_early_rvalid", 32'(x_rvalid_o), 0);
    step();
    check("mac_rvalid", 32'(x_rvalid_o), 1);
    check("mac_data",   x_data_o, 32'd17);
    check("mac_rd",     32'(x_rd_o), 7);
    step();

    // rd not clean holds ready low
    x_rd_clean_i = 1'b0;
    offer(enc(3'd0, 5'd8, 7'h0B), 32'd1, 32'd2, 32'd0);
    check("dirty_ready1", 32'(x_ready_o), 0);
    step();
    check("dirty_ready2", 32'(x_ready_o), 0);
    x_rd_clean_i = 1'b1;
    #1;
    check("clean_ready", 32'(x_ready_o), 1);
    drop();

    // Reset while BUSY with a result already queued
    x_rready_i = 1'b0;
    offer(enc(3'd0, 5'd1, 7'h0B), 32'd1, 32'd1, 32'd0);
    step();
    offer(enc(3'd3, 5'd2, 7'h0B), 32'd2, 32'd3, 32'd0);
    check("rb_mul_ready", 32'(x_ready_o), 1);
    step();
    drop();
    check("rb_queued", 32'(x_rvalid_o), 1);
    rst_i = 1'b1;
    #1;
    check("rb_rst_ready", 32'(x_ready_o), 0);
    step();
    rst_i = 1'b0;
    #1;
    check("rb_rvalid", 32'(x_rvalid_o), 0);
    check("rb_data",   x_data_o, 0);
    check("rb_rd",     32'(x_rd_o), 0);
    x_rready_i = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (x_rvalid_o) seen++;
      step();
    end
    check("rb_no_resp", 32'(seen), 0);

    // funct3=7 error op
    offer(enc(3'd7, 5'd9, 7'h0B), 32'd1, 32'd2, 32'd0);
`ifdef CV32E40P_X_RESP_STUB_ERR_EN
    check("err_accept", 32'(x_accept_o), 1);
    check("err_wb",     32'(x_writeback_o), 1);
    step();
    drop();
    check("err_rvalid", 32'(x_rvalid_o), 1);
    check("err_flag",   32'(x_error_o), 1);
    check("err_data",   x_data_o, 0);
    check("err_rd",     32'(x_rd_o), 9);
    step();
`else
    check("f3_7_accept", 32'(x_accept_o), 0);
    step();
    drop();
    check("f3_7_rvalid", 32'(x_rvalid_o), 0);
    check("f3_7_error",  32'(x_error_o), 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
